aes_round_sched: RTL and testbench

Sequences the AES core datapath for one 128-bit block: load, pre-add key, NR-1 full rounds, final round, result hand-off.
Sits between the bus-side controller/buffer and the AES core (state register, round datapath, key generator).
Arbitrates between block jobs and key-change requests; a key change is never applied while a block is in flight.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_rk_index.sv | 20 ++
 rtl/flex_counter.sv | 36 +++
 rtl/aes_round_sched.sv | 213 +++++++++++++++++++++
 tb/tb_aes_round_sched.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round scheduler.
package aes_pkg;

  // Scheduler FSM states; the 3-bit encoding is fully populated.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY_CHG = 3'd1,
    LOAD    = 3'd2,
    PREADD  = 3'd3,
    ROUND   = 3'd4,
    FINAL   = 3'd5,
    WAITLAT = 3'd6,
    HOLD    = 3'd7
  } sched_state_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // Width of the round-key index bus and of the round counter.
  localparam int RK_IDX_W = 4;

  // Width of the inter-request spacing counter (ROUND_LAT up to 8).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/aes_rk_index.sv
// Maps the logical round number to the key-schedule index; the inverse cipher
// walks the schedule backwards.
module aes_rk_index
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic [RK_IDX_W-1:0] round,
  input  logic                inv,
  output logic [RK_IDX_W-1:0] rk_idx
);

  localparam logic [RK_IDX_W-1:0] NR_L = RK_IDX_W'(NR);

  // Forward: index equals round. Inverse: index counts down from NR.
  always_comb begin
    rk_idx = inv ? (NR_L - round) : round;
  end

endmodule

// File: rtl/flex_counter.sv
// Loadable down-counter that stops at zero; used as the round-key spacing timer.
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/aes_round_sched.sv
// AES round scheduler: sequences load, initial AddRoundKey, NR-1 full rounds,
// final round and result hand-off, and arbitrates key changes between blocks.
// Optional build macro AES_SCHED_PERF_EN adds stall_cnt / blk_cnt counters.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic                enc_dec,
  input  logic                key_chg_req,
  input  logic                key_chg_done,
  output logic                key_load,
  output logic                key_valid,
  output logic                rk_req,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic                rk_ack,
  output logic                dp_load,
  output logic                dp_preadd,
  output logic                dp_round,
  output logic                dp_final,
  output logic                dp_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
`ifdef AES_SCHED_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         blk_cnt
`endif
);

  localparam logic [RK_IDX_W-1:0] NR_L        = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] NR_M1       = RK_IDX_W'(NR - 1);
  localparam logic [WAIT_W-1:0]   WAIT_RELOAD = WAIT_W'(ROUND_LAT - 1);

  sched_state_t        state_q, state_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic                key_valid_q, key_valid_d;
  logic                inv_q, inv_d;

  logic [WAIT_W-1:0]   wait_cnt;
  logic                in_rk_state;
  logic                rk_fire;
  logic [RK_IDX_W-1:0] rk_round;
  logic [RK_IDX_W-1:0] rk_idx_raw;

  // Spacing timer: reloaded on every accepted round key, requests wait for zero.
  flex_counter #(
    .W (WAIT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rk_fire),
    .load_val (WAIT_RELOAD),
    .dec      (1'b1),
    .cnt      (wait_cnt)
  );

  aes_rk_index #(
    .NR (NR)
  ) u_rk_index (
    .round  (rk_round),
    .inv    (inv_q),
    .rk_idx (rk_idx_raw)
  );

  // Key-request handshake and datapath strobes; strobes land on the ack cycle.
  always_comb begin
    in_rk_state = (state_q == PREADD) || (state_q == ROUND) || (state_q == FINAL);
    rk_req      = in_rk_state && (wait_cnt == '0);
    rk_fire     = rk_req && rk_ack;

    // Pre-add uses logical round 0, final round uses logical round NR.
    case (state_q)
      PREADD:  rk_round = '0;
      ROUND:   rk_round = round_q;
      FINAL:   rk_round = NR_L;
      default: rk_round = '0;
    endcase

    rk_idx    = rk_req ? rk_idx_raw : '0;
    dp_preadd = rk_fire && (state_q == PREADD);
    dp_round  = rk_fire && (state_q == ROUND);
    dp_final  = rk_fire && (state_q == FINAL);

    // Key changes take priority over a waiting block.
    blk_ready = (state_q == IDLE) && !key_chg_req && blk_valid && key_valid_q;

    key_load  = (state_q == KEY_CHG);
    dp_load   = (state_q == LOAD);
    out_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
    key_valid = key_valid_q;
    dp_inv    = inv_q;
  end

  // Next-state, round counter, key-valid flag and cipher direction.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    key_valid_d = key_valid_q;
    inv_d       = inv_q;

    case (state_q)
      IDLE: begin
        if (key_chg_req) begin
          state_d = KEY_CHG;
        end else if (blk_valid && key_valid_q) begin
          inv_d   = enc_dec;
          round_d = '0;
          state_d = LOAD;
        end
      end
      KEY_CHG: begin
        if (key_chg_done) begin
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      LOAD: begin
        state_d = PREADD;
      end
      PREADD: begin
        if (rk_fire) begin
          round_d = RK_IDX_W'(1);
          state_d = (NR == 1) ? FINAL : ROUND;
        end
      end
      ROUND: begin
        if (rk_fire) begin
          if (round_q == NR_M1) begin
            state_d = FINAL;
          end else begin
            round_d = round_q + RK_IDX_W'(1);
          end
        end
      end
      FINAL: begin
        // The final ack cycle is the first of the ROUND_LAT drain cycles.
        if (rk_fire) begin
          state_d = (ROUND_LAT == 1) ? HOLD : WAITLAT;
        end
      end
      WAITLAT: begin
        if (wait_cnt <= WAIT_W'(1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          round_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        round_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state registers; reset abandons any block and forgets the key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      key_valid_q <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      key_valid_q <= key_valid_d;
      inv_q       <= inv_d;
    end
  end

`ifdef AES_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;

  // Saturating counters for key-bus stalls and delivered blocks.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    if (rk_req && !rk_ack && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (out_valid && out_ready && (blk_cnt_q != '1)) begin
      blk_cnt_d = blk_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      blk_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign blk_cnt   = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched (NR=10, ROUND_LAT=1).
module tb_aes_round_sched;

  localparam int NR = 10;
  localparam int NC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       blk_valid, blk_ready, enc_dec;
  logic       key_chg_req, key_chg_done, key_load, key_valid;
  logic       rk_req, rk_ack;
  logic [3:0] rk_idx;
  logic       dp_load, dp_preadd, dp_round, dp_final, dp_inv;
  logic       out_valid, out_ready, busy;
`ifdef AES_SCHED_PERF_EN
  logic [31:0] stall_cnt, blk_cnt;
`endif

  always #5 clk = ~clk;

  aes_round_sched #(.NR(NR), .ROUND_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .enc_dec      (enc_dec),
    .key_chg_req  (key_chg_req),
    .key_chg_done (key_chg_done),
    .key_load     (key_load),
    .key_valid    (key_valid),
    .rk_req       (rk_req),
    .rk_idx       (rk_idx),
    .rk_ack       (rk_ack),
    .dp_load      (dp_load),
    .dp_preadd    (dp_preadd),
    .dp_round     (dp_round),
    .dp_final     (dp_final),
    .dp_inv       (dp_inv),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
`ifdef AES_SCHED_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .blk_cnt      (blk_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run, per-cycle captures (cycle 0 = accept cycle).
  logic [3:0] cap_idx [4][NC];
  logic       cap_req [4][NC];
  logic       cap_pre [4][NC];
  logic       cap_rnd [4][NC];
  logic       cap_fin [4][NC];
  logic       cap_ov  [4][NC];
  logic       cap_inv [4][NC];
  logic       cap_kl  [4][NC];
  logic       cap_br  [4][NC];

  typedef struct {
    int         run;
    int         cyc;
    logic [3:0] idx;
    logic       pre;
    logic       rnd;
    logic       fin;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one block starting in IDLE; optional ack stall window and key request.
  task automatic run_block(input int r, input logic dec, input int st_start,
                           input int st_len, input int kreq_at);
    enc_dec   = dec;
    blk_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < NC; c++) begin
      rk_ack = !(c >= st_start && c < st_start + st_len);
      if (kreq_at >= 0 && c >= kreq_at) key_chg_req = 1'b1;
      @(negedge clk);
      cap_idx[r][c] = rk_idx;
      cap_req[r][c] = rk_req;
      cap_pre[r][c] = dp_preadd;
      cap_rnd[r][c] = dp_round;
      cap_fin[r][c] = dp_final;
      cap_ov[r][c]  = out_valid;
      cap_inv[r][c] = dp_inv;
      cap_kl[r][c]  = key_load;
      cap_br[r][c]  = blk_ready;
      @(posedge clk); #1;
      blk_valid = 1'b0;
    end
    rk_ack    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("run%0d_handoff_ov", r), 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic int first_ov(input int r);
    for (int c = 0; c < NC; c++) if (cap_ov[r][c]) return c;
    return -1;
  endfunction

  function automatic int cnt_of(input int r, input int which);
    int n = 0;
    for (int c = 0; c < NC; c++) begin
      case (which)
        0: n += int'(cap_pre[r][c]);
        1: n += int'(cap_rnd[r][c]);
        2: n += int'(cap_fin[r][c]);
        3: n += int'(cap_kl[r][c]);
        4: n += (int'(cap_pre[r][c]) + int'(cap_rnd[r][c]) + int'(cap_fin[r][c]) > 1) ? 1 : 0;
        default: n += 0;
      endcase
    end
    return n;
  endfunction

  function automatic int inv_cnt(input int r);
    int n = 0;
    for (int c = 1; c <= 13; c++) n += int'(cap_inv[r][c]);
    return n;
  endfunction

  initial begin
    int kl_cnt;
    vec_t v;

    // Expected key-index sequence for the encrypt (run 0) and decrypt (run 1) blocks.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i <= NR; i++) begin
        v.run = r;
        v.cyc = 2 + i;
        v.idx = (r == 1) ? 4'(NR - i) : 4'(i);
        v.pre = (i == 0);
        v.rnd = (i > 0) && (i < NR);
        v.fin = (i == NR);
        tbl.push_back(v);
      end
    end

    rst = 1'b1; blk_valid = 1'b0; enc_dec = 1'b0; key_chg_req = 1'b0;
    key_chg_done = 1'b0; rk_ack = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_rk_req", 32'(rk_req), 32'd0);
    chk("rst_rk_idx", 32'(rk_idx), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_key_load", 32'(key_load), 32'd0);
    chk("rst_dp_inv", 32'(dp_inv), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Block waiting without a key is not accepted.
    blk_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("nokey_blk_ready%0d", k), 32'(blk_ready), 32'd0);
      chk($sformatf("nokey_busy%0d", k), 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    // Key change: done arrives in the fifth KEY_CHG cycle.
    key_chg_req = 1'b1;
    @(posedge clk); #1;
    key_chg_req = 1'b0;
    kl_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) key_chg_done = 1'b1;
      @(negedge clk);
      kl_cnt += int'(key_load);
      @(posedge clk); #1;
      key_chg_done = 1'b0;
    end
    chk("key_load_cycles", 32'(kl_cnt), 32'd5);
    chk("key_valid_set", 32'(key_valid), 32'd1);
    chk("key_load_after", 32'(key_load), 32'd0);

    run_block(0, 1'b0, -1, 0, -1);
    run_block(1, 1'b1, -1, 0, -1);
    run_block(2, 1'b0, 6, 3, -1);
    run_block(3, 1'b0, -1, 0, 5);

    // Pending key change is served before the waiting block.
    blk_valid = 1'b1;
    @(negedge clk);
    chk("kreq_priority_blk_ready", 32'(blk_ready), 32'd0);
    chk("kreq_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    key_chg_req = 1'b0;
    @(negedge clk);
    chk("kreq_served_key_load", 32'(key_load), 32'd1);
    chk("kreq_served_blk_ready", 32'(blk_ready), 32'd0);
    key_chg_done = 1'b1;
    @(posedge clk); #1;
    key_chg_done = 1'b0;

    // Reset during round 5 of a decrypt block.
    enc_dec = 1'b1;
    rk_ack  = 1'b1;
    @(negedge clk);
    chk("post_key_blk_ready", 32'(blk_ready), 32'd1);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_idx_before", 32'(rk_idx), 32'd5);
    chk("midrst_round_before", 32'(dp_round), 32'd1);
    chk("midrst_inv_before", 32'(dp_inv), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rk_req", 32'(rk_req), 32'd0);
    chk("midrst_dp_round", 32'(dp_round), 32'd0);
    chk("midrst_dp_inv", 32'(dp_inv), 32'd0);
    chk("midrst_key_valid", 32'(key_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    blk_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_nokey_blk_ready%0d", k), 32'(blk_ready), 32'd0);
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;

    // Table of expected round-key requests and strobes.
    foreach (tbl[i]) begin
      v = tbl[i];
      chk($sformatf("tbl%0d_run%0d_c%0d_idx", i, v.run, v.cyc), 32'(cap_idx[v.run][v.cyc]), 32'(v.idx));
      chk($sformatf("tbl%0d_req", i), 32'(cap_req[v.run][v.cyc]), 32'd1);
      chk($sformatf("tbl%0d_pre", i), 32'(cap_pre[v.run][v.cyc]), 32'(v.pre));
      chk($sformatf("tbl%0d_rnd", i), 32'(cap_rnd[v.run][v.cyc]), 32'(v.rnd));
      chk($sformatf("tbl%0d_fin", i), 32'(cap_fin[v.run][v.cyc]), 32'(v.fin));
    end

    // Whole-run properties.
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("run%0d_accept", r), 32'(cap_br[r][0]), 32'd1);
      chk($sformatf("run%0d_first_ov", r), 32'(first_ov(r)), (r == 2) ? 32'd16 : 32'd13);
      chk($sformatf("run%0d_n_preadd", r), 32'(cnt_of(r, 0)), 32'd1);
      chk($sformatf("run%0d_n_round", r), 32'(cnt_of(r, 1)), 32'd9);
      chk($sformatf("run%0d_n_final", r), 32'(cnt_of(r, 2)), 32'd1);
      chk($sformatf("run%0d_overlap", r), 32'(cnt_of(r, 4)), 32'd0);
      chk($sformatf("run%0d_inv_cycles", r), 32'(inv_cnt(r)), (r == 1) ? 32'd13 : 32'd0);
    end
    chk("run0_load_cycle", 32'(cap_req[0][1]), 32'd0);

    // Stalled ack at round 4.
    for (int c = 6; c <= 9; c++) begin
      chk($sformatf("stall_c%0d_req", c), 32'(cap_req[2][c]), 32'd1);
      chk($sformatf("stall_c%0d_idx", c), 32'(cap_idx[2][c]), 32'd4);
      chk($sformatf("stall_c%0d_rnd", c), 32'(cap_rnd[2][c]), (c == 9) ? 32'd1 : 32'd0);
    end
    chk("stall_c15_final", 32'(cap_fin[2][15]), 32'd1);

    // Key request raised mid-block must not start expansion.
    chk("kreq_midblock_key_load", 32'(cnt_of(3, 3)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
